// File: rtl/cascade_mon_pkg.sv
// Shared types and limits for the cascade_and pipeline monitor.
package cascade_mon_pkg;

    localparam int LANES       = 2;
    localparam int MAX_LATENCY = 8;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        CHECK  = 2'd1,
        HALT   = 2'd2
    } mon_state_e;

endpackage

// File: rtl/cascade_and_monitor_if.sv
// Monitor bundle: pipeline stimulus/outputs in, check results out.
interface cascade_and_monitor_if #(
    parameter int CNT_W = 16
);
    import cascade_mon_pkg::*;

    logic             clear;
    logic             d0;
    logic             d1;
    logic             q0;
    logic             q1;
    logic             warm;
    logic             mismatch;
    logic [LANES-1:0] err_lanes;
    logic             err_sticky;
    logic [CNT_W-1:0] check_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output clear, d0, d1, q0, q1,
        input  warm, mismatch, err_lanes, err_sticky, check_cnt, err_cnt
    );

    modport slave (
        input  clear, d0, d1, q0, q1,
        output warm, mismatch, err_lanes, err_sticky, check_cnt, err_cnt
    );

endinterface

// File: rtl/cascade_delay_line.sv
// Fixed-depth shift register reproducing the monitored pipeline's latency.
module cascade_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: the stages are reset on purpose: reset must flush stale history, and non-blocking
    // assignment makes every stage take its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/cascade_and_monitor.sv
// Checker for the two-lane cascade_and pipeline (q0 = d0, q1 = d0 & d1 after LATENCY).
// Define CASCADE_MON_STOP_ON_ERR_EN to halt checking at the first miscompare.
module cascade_and_monitor
    import cascade_mon_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    cascade_and_monitor_if.slave mon
);

    localparam int WC_W = $clog2(MAX_LATENCY);

    mon_state_e       state;
    logic [WC_W-1:0]  warm_cnt;
    logic [LANES-1:0] exp_q;
    logic [LANES-1:0] diff;
    logic             mismatch_r;
    logic [LANES-1:0] err_lanes_r;
    logic             err_sticky_r;
    logic [CNT_W-1:0] check_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;

    // The AND is formed before the delay so exp_q[1] is the expected q1 directly.
    cascade_delay_line #(
        .WIDTH(LANES),
        .DEPTH(LATENCY)
    ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({mon.d0 & mon.d1, mon.d0}),
        .dout (exp_q)
    );

    assign diff = {mon.q1, mon.q0} ^ exp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= WARMUP;
            warm_cnt     <= '0;
            mismatch_r   <= 1'b0;
            err_lanes_r  <= '0;
            err_sticky_r <= 1'b0;
            check_cnt_r  <= '0;
            err_cnt_r    <= '0;
        end else begin
            mismatch_r <= 1'b0;
            case (state)
                WARMUP: begin
                    if (warm_cnt == WC_W'(LATENCY - 1)) state <= CHECK;
                    else                                 warm_cnt <= warm_cnt + 1'b1;
                end
                CHECK: begin
                    if (!mon.clear) begin
                        if (check_cnt_r != '1) check_cnt_r <= check_cnt_r + 1'b1;
                        if (|diff) begin
                            mismatch_r   <= 1'b1;
                            err_lanes_r  <= diff;
                            err_sticky_r <= 1'b1;
                            if (err_cnt_r != '1) err_cnt_r <= err_cnt_r + 1'b1;
`ifdef CASCADE_MON_STOP_ON_ERR_EN
                            state <= HALT;
`endif
                        end
                    end
                end
                HALT: begin
                    if (mon.clear) state <= CHECK;
                end
                default: state <= WARMUP;
            endcase
            // Clear wipes results only; warm-up progress and the delay line are kept.
            if (mon.clear) begin
                err_lanes_r  <= '0;
                err_sticky_r <= 1'b0;
                check_cnt_r  <= '0;
                err_cnt_r    <= '0;
            end
        end
    end

    assign mon.warm       = (state != WARMUP);
    assign mon.mismatch   = mismatch_r;
    assign mon.err_lanes  = err_lanes_r;
    assign mon.err_sticky = err_sticky_r;
    assign mon.check_cnt  = check_cnt_r;
    assign mon.err_cnt    = err_cnt_r;

endmodule
